// File: rtl/core_csr_file.sv
// core_csr_file: machine-mode CSR register file.
// Two write ports: execute stage (csrrw/s/c, final value) and interrupt controller.
// The interrupt port wins on an address collision. Owns the free-running 64-bit mcycle.
// Optional build macro CSR_MINSTRET_EN adds a 64-bit minstret counter at B02/B82.
module core_csr_file #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [AW-1:0] ex_raddr_i,
    output logic [DW-1:0] ex_rdata_o,
    input  logic          ex_we_i,
    input  logic [AW-1:0] ex_waddr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic          int_we_i,
    input  logic [AW-1:0] int_waddr_i,
    input  logic [DW-1:0] int_wdata_i,
    input  logic          inst_retire_i,
    output logic [DW-1:0] csr_mtvec_o,
    output logic [DW-1:0] csr_mepc_o,
    output logic [DW-1:0] csr_mstatus_o,
    output logic          mie_en_o
);
    localparam int unsigned HW  = 32;
    localparam int unsigned HW1 = HW + 1;
    localparam int unsigned CW  = 2 * HW;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_CYC_LO   = 12'hB00;
    localparam logic [11:0] A_CYC_HI   = 12'hB80;

    localparam int unsigned I_MSTATUS  = 0;
    localparam int unsigned I_MIE      = 1;
    localparam int unsigned I_MTVEC    = 2;
    localparam int unsigned I_MSCRATCH = 3;
    localparam int unsigned I_MEPC     = 4;
    localparam int unsigned I_MCAUSE   = 5;
    localparam int unsigned I_CYC_LO   = 6;
    localparam int unsigned I_CYC_HI   = 7;
`ifdef CSR_MINSTRET_EN
    localparam logic [11:0] A_INS_LO   = 12'hB02;
    localparam logic [11:0] A_INS_HI   = 12'hB82;
    localparam int unsigned I_INS_LO   = 8;
    localparam int unsigned I_INS_HI   = 9;
    localparam int unsigned NREG       = 10;
`else
    localparam int unsigned NREG       = 8;
`endif

    logic [DW-1:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
    logic [CW-1:0] r_mcycle;

    logic [11:0]                w_ra, w_ex_wa, w_int_wa;
    logic [NREG-1:0]            w_ex_hit, w_int_hit, w_hit;
    logic [NREG-1:0][DW-1:0]    w_wd;
    logic [CW-1:0]              w_mcycle_nxt;
    logic                       w_unused_bits;

    // One-hot decode of a 12-bit CSR address; unmapped addresses decode to zero.
    function automatic logic [NREG-1:0] f_dec(input logic [11:0] a);
        f_dec = '0;
        case (a)
            A_MSTATUS:  f_dec[I_MSTATUS]  = 1'b1;
            A_MIE:      f_dec[I_MIE]      = 1'b1;
            A_MTVEC:    f_dec[I_MTVEC]    = 1'b1;
            A_MSCRATCH: f_dec[I_MSCRATCH] = 1'b1;
            A_MEPC:     f_dec[I_MEPC]     = 1'b1;
            A_MCAUSE:   f_dec[I_MCAUSE]   = 1'b1;
            A_CYC_LO:   f_dec[I_CYC_LO]   = 1'b1;
            A_CYC_HI:   f_dec[I_CYC_HI]   = 1'b1;
`ifdef CSR_MINSTRET_EN
            A_INS_LO:   f_dec[I_INS_LO]   = 1'b1;
            A_INS_HI:   f_dec[I_INS_HI]   = 1'b1;
`endif
            default:    f_dec = '0;
        endcase
    endfunction

    // 64-bit counter step: a written half takes the written value; a written high half
    // swallows the low-half carry, a written low half still lets its old carry reach the high half.
    function automatic logic [CW-1:0] f_cnt(input logic [CW-1:0] cur, input logic inc,
                                            input logic lo_wr, input logic [HW-1:0] lo_d,
                                            input logic hi_wr, input logic [HW-1:0] hi_d);
        logic [HW:0]   lo_sum;
        logic [HW-1:0] hi_sum;
        lo_sum = {1'b0, cur[HW-1:0]} + HW1'(inc);
        hi_sum = cur[CW-1:HW] + HW'(lo_sum[HW]);
        f_cnt  = {(hi_wr ? hi_d : hi_sum), (lo_wr ? lo_d : lo_sum[HW-1:0])};
    endfunction

    assign w_ra     = ex_raddr_i[11:0];
    assign w_ex_wa  = ex_waddr_i[11:0];
    assign w_int_wa = int_waddr_i[11:0];

    // Per-register write strobes and data; the interrupt port overrides the execute port.
    always_comb begin
        w_ex_hit  = ex_we_i  ? f_dec(w_ex_wa)  : '0;
        w_int_hit = int_we_i ? f_dec(w_int_wa) : '0;
        w_hit     = w_ex_hit | w_int_hit;
        for (int i = 0; i < int'(NREG); i++) begin
            w_wd[i] = w_int_hit[i] ? int_wdata_i : ex_wdata_i;
        end
    end

    assign w_mcycle_nxt = f_cnt(r_mcycle, 1'b1,
                                w_hit[I_CYC_LO], HW'(w_wd[I_CYC_LO]),
                                w_hit[I_CYC_HI], HW'(w_wd[I_CYC_HI]));

    // CSR storage and mcycle counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mcycle   <= '0;
        end else begin
            if (w_hit[I_MSTATUS])  r_mstatus  <= w_wd[I_MSTATUS];
            if (w_hit[I_MIE])      r_mie      <= w_wd[I_MIE];
            if (w_hit[I_MTVEC])    r_mtvec    <= w_wd[I_MTVEC];
            if (w_hit[I_MSCRATCH]) r_mscratch <= w_wd[I_MSCRATCH];
            if (w_hit[I_MEPC])     r_mepc     <= w_wd[I_MEPC];
            if (w_hit[I_MCAUSE])   r_mcause   <= w_wd[I_MCAUSE];
            r_mcycle <= w_mcycle_nxt;
        end
    end

`ifdef CSR_MINSTRET_EN
    logic [CW-1:0] r_minstret;
    logic [CW-1:0] w_minstret_nxt;

    assign w_minstret_nxt = f_cnt(r_minstret, inst_retire_i,
                                  w_hit[I_INS_LO], HW'(w_wd[I_INS_LO]),
                                  w_hit[I_INS_HI], HW'(w_wd[I_INS_HI]));

    // Retired-instruction counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_minstret <= '0;
        else          r_minstret <= w_minstret_nxt;
    end

    assign w_unused_bits = ^{ex_raddr_i[AW-1:12], ex_waddr_i[AW-1:12], int_waddr_i[AW-1:12]};
`else
    assign w_unused_bits = ^{ex_raddr_i[AW-1:12], ex_waddr_i[AW-1:12], int_waddr_i[AW-1:12],
                             inst_retire_i};
`endif

    // Execute-stage read mux; unmapped addresses read zero.
    always_comb begin
        ex_rdata_o = '0;
        case (w_ra)
            A_MSTATUS:  ex_rdata_o = r_mstatus;
            A_MIE:      ex_rdata_o = r_mie;
            A_MTVEC:    ex_rdata_o = r_mtvec;
            A_MSCRATCH: ex_rdata_o = r_mscratch;
            A_MEPC:     ex_rdata_o = r_mepc;
            A_MCAUSE:   ex_rdata_o = r_mcause;
            A_CYC_LO:   ex_rdata_o = DW'(r_mcycle[HW-1:0]);
            A_CYC_HI:   ex_rdata_o = DW'(r_mcycle[CW-1:HW]);
`ifdef CSR_MINSTRET_EN
            A_INS_LO:   ex_rdata_o = DW'(r_minstret[HW-1:0]);
            A_INS_HI:   ex_rdata_o = DW'(r_minstret[CW-1:HW]);
`endif
            default:    ex_rdata_o = '0;
        endcase
    end

    assign csr_mtvec_o   = r_mtvec;
    assign csr_mepc_o    = r_mepc;
    assign csr_mstatus_o = r_mstatus;
    assign mie_en_o      = r_mstatus[3];

endmodule
